local_node: RTL

Traffic endpoint attached to a router's local port. Injects packets on the router's local RX serial channel and sinks packets from the router's local TX serial channel. Each injected item carries a pseudo-random destination and a sequence number. Each received item is checked against the node's own id. Counters expose injection, reception and misdelivery totals to the testbench and to activity monitoring.

---
 rtl/local_node.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/local_node.sv
`default_nettype none
// ============================================================================
// local_node : router local-port endpoint; injects LFSR-addressed serial frames
//              and sinks/checks frames addressed to NODE_ID.
// Revision   : 1.0
// ============================================================================
module local_node #(
  parameter int         NODE_ID = 0,
  parameter int         SIZE    = 8,
  parameter int         ID_BITS = 4,
  parameter int         GAP     = 16,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            tx_data,
  input  logic            tx_busy,
  input  logic            rx_data,
  output logic            rx_busy,
  output logic [15:0]     sent_count,
  output logic [15:0]     recv_count,
  output logic [15:0]     err_count,
  output logic [SIZE-1:0] last_item
);

  localparam int                 c_seq_w    = SIZE - ID_BITS;
  localparam int                 c_gap_w    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int                 c_bit_w    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ID_BITS-1:0] c_node_id  = ID_BITS'(NODE_ID);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(SIZE - 1);

  typedef enum logic [1:0] {T_GAP, T_ARM, T_START, T_DATA} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_CHECK}       rx_state_t;

  // ---------------------------------------------------------------- TX path
  tx_state_t           r_tx_state;
  tx_state_t           w_tx_next;
  logic [c_gap_w-1:0]  r_gap_cnt;
  logic [c_bit_w-1:0]  r_tx_bit;
  logic [SIZE-1:0]     r_tx_shift;
  logic                r_tx_data;
  logic [c_seq_w-1:0]  r_seq;
  logic [7:0]          r_lfsr;
  logic [15:0]         r_sent;

  logic                w_gap_done;
  logic                w_tx_load;
  logic                w_tx_done;
  logic [ID_BITS-1:0]  w_dest;
  logic [SIZE-1:0]     w_item;
  logic [7:0]          w_lfsr_next;

  assign w_gap_done  = (r_gap_cnt == c_gap_last);
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  // Never address ourselves: bump the destination by one when the LFSR lands on NODE_ID.
  assign w_dest      = (r_lfsr[ID_BITS-1:0] == c_node_id) ? c_node_id + ID_BITS'(1)
                                                          : r_lfsr[ID_BITS-1:0];
  assign w_item      = {r_seq, w_dest};

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    w_tx_done = 1'b0;
    case (r_tx_state)
      T_GAP:   if (w_gap_done) w_tx_next = T_ARM;
      T_ARM: begin
        if (enable && !tx_busy) begin
          w_tx_next = T_START;
          w_tx_load = 1'b1;
        end
      end
      T_START: w_tx_next = T_DATA;
      T_DATA: begin
        if (r_tx_bit == c_bit_last) begin
          w_tx_next = T_GAP;
          w_tx_done = 1'b1;
        end
      end
      default: w_tx_next = T_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_state <= T_GAP;
      r_gap_cnt  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_data  <= 1'b0;
      r_seq      <= '0;
      r_lfsr     <= SEED;
      r_sent     <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      r_gap_cnt  <= (r_tx_state == T_GAP && !w_gap_done) ? r_gap_cnt + c_gap_w'(1) : '0;

      // Line carries the start bit after the load edge, then one data bit per edge.
      if (w_tx_load) begin
        r_tx_shift <= w_item;
        r_tx_data  <= 1'b1;
      end else if (r_tx_state == T_START || (r_tx_state == T_DATA && !w_tx_done)) begin
        r_tx_data  <= r_tx_shift[0];
        r_tx_shift <= r_tx_shift >> 1;
      end else begin
        r_tx_data  <= 1'b0;
      end

      if (r_tx_state == T_START) begin
        r_tx_bit <= '0;
      end else if (r_tx_state == T_DATA && !w_tx_done) begin
        r_tx_bit <= r_tx_bit + c_bit_w'(1);
      end

      if (w_tx_done) begin
        r_seq  <= r_seq + c_seq_w'(1);
        r_lfsr <= w_lfsr_next;
        if (r_sent != 16'hFFFF) r_sent <= r_sent + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  rx_state_t           r_rx_state;
  rx_state_t           w_rx_next;
  logic [c_bit_w-1:0]  r_rx_bit;
  logic [SIZE-1:0]     r_rx_shift;
  logic [SIZE-1:0]     r_last;
  logic [15:0]         r_recv;
  logic [15:0]         r_err;
  logic                w_rx_check;

  always_comb begin
    w_rx_next  = r_rx_state;
    w_rx_check = 1'b0;
    case (r_rx_state)
      R_IDLE:  if (rx_data) w_rx_next = R_DATA;
      R_DATA:  if (r_rx_bit == c_bit_last) w_rx_next = R_CHECK;
      R_CHECK: begin
        w_rx_next  = R_IDLE;
        w_rx_check = 1'b1;
      end
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_state <= R_IDLE;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_last     <= '0;
      r_recv     <= '0;
      r_err      <= '0;
    end else begin
      r_rx_state <= w_rx_next;

      // LSB arrives first, so shift in at the top and let it walk down.
      if (r_rx_state == R_DATA) begin
        r_rx_shift <= {rx_data, r_rx_shift[SIZE-1:1]};
        r_rx_bit   <= r_rx_bit + c_bit_w'(1);
      end else begin
        r_rx_bit   <= '0;
      end

      if (w_rx_check) begin
        r_last <= r_rx_shift;
        if (r_recv != 16'hFFFF) r_recv <= r_recv + 16'd1;
        if (r_rx_shift[ID_BITS-1:0] != c_node_id && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign rx_busy    = (r_rx_state != R_IDLE);
  assign sent_count = r_sent;
  assign recv_count = r_recv;
  assign err_count  = r_err;
  assign last_item  = r_last;

endmodule
`default_nettype wire
